// File: rtl/melody_sequencer_if.sv
// Control/status bundle between the register glue (master) and melody_sequencer (slave).
// The loop input exists only when MELODY_LOOP_EN is defined.
interface melody_sequencer_if #(
    parameter int DEPTH = 16
) ();
    localparam int AW = $clog2(DEPTH);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          start;
    logic          stop;
`ifdef MELODY_LOOP_EN
    logic          loop;
`endif
    logic          busy;
    logic          done;
    logic [AW-1:0] cur_idx;
    logic          pwm_en;
    logic [19:0]   pwm_parameter;

    modport master (
`ifdef MELODY_LOOP_EN
        output loop,
`endif
        output wr_en, wr_addr, wr_data, start, stop,
        input  busy, done, cur_idx, pwm_en, pwm_parameter
    );

    modport slave (
`ifdef MELODY_LOOP_EN
        input  loop,
`endif
        input  wr_en, wr_addr, wr_data, start, stop,
        output busy, done, cur_idx, pwm_en, pwm_parameter
    );
endinterface

// File: rtl/melody_sequencer.sv
// Table-driven note sequencer driving the tone PWM: each entry plays for duration x TICK_DIV
// cycles followed by a GAP_CYC silent gap. Repeat mode is compiled in with MELODY_LOOP_EN.
module melody_sequencer #(
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 50000,
    parameter int GAP_CYC  = 2500
) (
    input  logic               clk,
    input  logic               rst_n,
    melody_sequencer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TW-1:0] TICK_LOAD = TW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    typedef struct packed {
        logic        last;
        logic [7:0]  dur;
        logic [19:0] period;
    } entry_t;

    state_t        state_q, state_d, after_note;
    entry_t        note_tab [DEPTH];
    entry_t        rd_entry;
    logic [AW-1:0] idx_q;
    logic [19:0]   period_q, play_period;
    logic          last_q, loop_q;
    logic [TW-1:0] tick_cnt;
    logic [7:0]    dur_cnt;
    logic [GW-1:0] gap_cnt;
    logic          play_end, gap_end, at_end;
    logic          busy_q, done_q, pwm_en_q;
    logic [19:0]   pwm_par_q;
    logic          busy_d, done_d, pwm_en_d;
    logic [19:0]   pwm_par_d;
    logic          unused_bits;

    assign unused_bits = ^bus.wr_data[31:29];

    // NOTE: the note table is reset entry by entry, so it is built from flops, not a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) note_tab[i] <= '0;
        end else if (bus.wr_en) begin
            note_tab[bus.wr_addr] <= entry_t'(bus.wr_data[28:0]);
        end
    end

    assign rd_entry   = note_tab[idx_q];
    assign play_end   = (tick_cnt == '0) && (dur_cnt == 8'd1);
    assign gap_end    = (gap_cnt == '0);
    assign at_end     = last_q || (idx_q == LAST_IDX);
    assign after_note = (at_end && !loop_q) ? IDLE : LOAD;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD;
            LOAD:    state_d = (rd_entry.dur == '0) ? IDLE : PLAY;
            PLAY:    if (play_end) state_d = (GAP_CYC == 0) ? after_note : GAP;
            GAP:     if (gap_end) state_d = after_note;
            default: state_d = IDLE;
        endcase
        if (bus.stop) state_d = IDLE;
    end

    // Outputs are computed from the next state and registered on the same edge.
    always_comb begin
        play_period = (state_q == LOAD) ? rd_entry.period : period_q;
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == IDLE) && (state_q != IDLE) && !bus.stop;
        pwm_en_d    = (state_d == PLAY) && (play_period != '0);
        pwm_par_d   = pwm_par_q;
        if (state_d == IDLE)      pwm_par_d = '0;
        else if (state_d == PLAY) pwm_par_d = play_period;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pwm_en_q  <= 1'b0;
            pwm_par_q <= '0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            pwm_en_q  <= pwm_en_d;
            pwm_par_q <= pwm_par_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            period_q <= '0;
            last_q   <= 1'b0;
            tick_cnt <= '0;
            dur_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            // Entering LOAD from IDLE or at end of table (loop wrap) restarts at entry 0.
            if (state_d == LOAD)
                idx_q <= (state_q == IDLE || at_end) ? '0 : idx_q + 1'b1;
            case (state_q)
                LOAD: begin
                    period_q <= rd_entry.period;
                    last_q   <= rd_entry.last;
                    dur_cnt  <= rd_entry.dur;
                    tick_cnt <= TICK_LOAD;
                end
                PLAY: begin
                    if (tick_cnt == '0) begin
                        dur_cnt  <= dur_cnt - 1'b1;
                        tick_cnt <= TICK_LOAD;
                        gap_cnt  <= GAP_LOAD;
                    end else begin
                        tick_cnt <= tick_cnt - 1'b1;
                    end
                end
                GAP:     gap_cnt <= gap_cnt - 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MELODY_LOOP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         loop_q <= 1'b0;
        else if (state_q == IDLE && bus.start) loop_q <= bus.loop;
    end
`else
    assign loop_q = 1'b0;
`endif

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pwm_en        = pwm_en_q;
    assign bus.pwm_parameter = pwm_par_q;
    assign bus.cur_idx       = idx_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: per-cycle output traces come from a note-level
// model of the table (load, play, gap, done) and are compared against the DUT.
module tb_melody_sequencer;
    localparam int DEPTH    = 4;
    localparam int TICK_DIV = 4;
    localparam int GAP_CYC  = 2;
    localparam int AW       = $clog2(DEPTH);

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          pwm_en;
        logic [19:0]   par;
        logic [AW-1:0] idx;
        logic          par_care;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mdl_tab [DEPTH];
    exp_t        exp_q [$];

    melody_sequencer_if #(.DEPTH(DEPTH)) bus ();

    melody_sequencer #(
        .DEPTH    (DEPTH),
        .TICK_DIV (TICK_DIV),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish within 2 ms");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(logic busy, logic done, logic en, logic [19:0] par, int idx, logic care);
        exp_t e;
        e.busy = busy; e.done = done; e.pwm_en = en; e.par = par;
        e.idx = idx[AW-1:0]; e.par_care = care;
        return e;
    endfunction

    function automatic exp_t observe();
        return mk(bus.busy, bus.done, bus.pwm_en, bus.pwm_parameter, int'(bus.cur_idx), 1'b1);
    endfunction

    function automatic string fmt(exp_t e);
        return $sformatf("busy=%b done=%b en=%b par=%0d idx=%0d", e.busy, e.done, e.pwm_en, e.par, e.idx);
    endfunction

    // Note-level model: appends the cycle-by-cycle outputs of one pass starting at entry 0.
    // LOAD cycles leave pwm_parameter unconstrained; with tail, one quiet IDLE cycle follows done.
    function automatic void build_trace(bit tail);
        int i = 0;
        for (int n = 0; n < DEPTH; n++) begin
            logic [19:0] p    = mdl_tab[i][19:0];
            int          d    = int'(mdl_tab[i][27:20]);
            logic        last = mdl_tab[i][28];
            exp_q.push_back(mk(1, 0, 0, 20'd0, i, 0));
            if (d == 0) break;
            repeat (d * TICK_DIV) exp_q.push_back(mk(1, 0, p != 0, p, i, 1));
            repeat (GAP_CYC)      exp_q.push_back(mk(1, 0, 0, p, i, 1));
            if (last || i == DEPTH - 1) break;
            i++;
        end
        exp_q.push_back(mk(0, 1, 0, 20'd0, i, 1));
        if (tail) exp_q.push_back(mk(0, 0, 0, 20'd0, i, 1));
    endfunction

    task automatic write_entry(input int addr, input logic [19:0] period, input int dur, input logic last);
        logic [31:0] w;
        w = {3'($urandom), last, 8'(dur), period};
        mdl_tab[addr] = w;
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(addr);
        bus.wr_data = w;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
    endtask

    task automatic test_reset();
        exp_t o;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.stop = 1'b0;
`ifdef MELODY_LOOP_EN
        bus.loop = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) mdl_tab[i] = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        o = observe();
        n_checks++;
        if (o !== mk(0, 0, 0, 20'd0, 0, 1)) begin
            n_errors++;
            $display("FAIL reset_held: got %s, expected all zero", fmt(o));
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0)          begin n_errors++; $display("FAIL reset_busy: got %b, expected 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0)          begin n_errors++; $display("FAIL reset_done: got %b, expected 0", bus.done); end
        n_checks++; if (bus.pwm_en !== 1'b0)        begin n_errors++; $display("FAIL reset_pwm_en: got %b, expected 0", bus.pwm_en); end
        n_checks++; if (bus.pwm_parameter !== '0)   begin n_errors++; $display("FAIL reset_par: got %0d, expected 0", bus.pwm_parameter); end
        n_checks++; if (bus.cur_idx !== '0)         begin n_errors++; $display("FAIL reset_idx: got %0d, expected 0", bus.cur_idx); end
    endtask

    // Plays one melody from the current table and follows the model trace.
    task automatic test_play(input string name);
        exp_t o;
        exp_q.delete();
        build_trace(1);
        pulse_start();
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            o = observe();
            n_checks++;
            if (o.busy !== exp_q[k].busy || o.done !== exp_q[k].done || o.pwm_en !== exp_q[k].pwm_en ||
                o.idx !== exp_q[k].idx || (exp_q[k].par_care && o.par !== exp_q[k].par)) begin
                n_errors++;
                $display("FAIL %s cyc %0d: got %s, expected %s", name, k, fmt(o), fmt(exp_q[k]));
            end
        end
    endtask

    task automatic test_two_note();
        write_entry(0, 20'd100, 3, 1'b0);
        write_entry(1, 20'd200, 2, 1'b1);
        test_play("two_note");
    endtask

    task automatic test_rest();
        write_entry(0, 20'd0, 2, 1'b1);
        test_play("rest");
    endtask

    task automatic test_terminator();
        write_entry(0, 20'd150, 1, 1'b0);
        write_entry(1, 20'd999, 0, 1'b0);
        test_play("terminator");
    endtask

    task automatic test_table_end();
        for (int i = 0; i < DEPTH; i++) write_entry(i, 20'(1000 + i), 1, 1'b0);
        test_play("table_end");
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < DEPTH; i++)
                write_entry(i, ($urandom_range(0, 4) == 0) ? 20'd0 : 20'($urandom),
                            ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3)),
                            $urandom_range(0, 2) == 0);
            test_play($sformatf("random%0d", it));
        end
    endtask

    task automatic test_stop();
        exp_t o;
        write_entry(0, 20'd123, 3, 1'b1);
        exp_q.delete();
        build_trace(1);
        while (exp_q.size() > 6) void'(exp_q.pop_back());
        repeat (2) exp_q.push_back(mk(0, 0, 0, 20'd0, 0, 1));
        pulse_start();
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.stop = 1'b0;
            o = observe();
            n_checks++;
            if (o.busy !== exp_q[k].busy || o.done !== exp_q[k].done || o.pwm_en !== exp_q[k].pwm_en ||
                o.idx !== exp_q[k].idx || (exp_q[k].par_care && o.par !== exp_q[k].par)) begin
                n_errors++;
                $display("FAIL stop cyc %0d: got %s, expected %s", k, fmt(o), fmt(exp_q[k]));
            end
            if (k == 3) bus.start = 1'b1;
            if (k == 5) bus.stop  = 1'b1;
        end
    endtask

    task automatic test_live_write();
        exp_t o;
        write_entry(0, 20'd100, 3, 1'b0);
        write_entry(1, 20'd200, 2, 1'b1);
        mdl_tab[1] = {3'b000, 1'b1, 8'd2, 20'd300};
        exp_q.delete();
        build_trace(1);
        pulse_start();
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.wr_en = 1'b0;
            o = observe();
            n_checks++;
            if (o.busy !== exp_q[k].busy || o.done !== exp_q[k].done || o.pwm_en !== exp_q[k].pwm_en ||
                o.idx !== exp_q[k].idx || (exp_q[k].par_care && o.par !== exp_q[k].par)) begin
                n_errors++;
                $display("FAIL live_write cyc %0d: got %s, expected %s", k, fmt(o), fmt(exp_q[k]));
            end
            if (k == 4) begin
                bus.wr_en = 1'b1; bus.wr_addr = AW'(1); bus.wr_data = mdl_tab[1];
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t o;
        int   a_len;
        write_entry(0, 20'd111, 1, 1'b0);
        write_entry(1, 20'd222, 1, 1'b1);
        exp_q.delete();
        build_trace(0);
        a_len = exp_q.size();
        build_trace(1);
        pulse_start();
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            o = observe();
            n_checks++;
            if (o.busy !== exp_q[k].busy || o.done !== exp_q[k].done || o.pwm_en !== exp_q[k].pwm_en ||
                o.idx !== exp_q[k].idx || (exp_q[k].par_care && o.par !== exp_q[k].par)) begin
                n_errors++;
                $display("FAIL back_to_back cyc %0d: got %s, expected %s", k, fmt(o), fmt(exp_q[k]));
            end
            if (k == a_len - 1) bus.start = 1'b1;
        end
    endtask

`ifdef MELODY_LOOP_EN
    task automatic test_loop();
        exp_t o;
        int   keep;
        write_entry(0, 20'd100, 1, 1'b0);
        write_entry(1, 20'd200, 1, 1'b1);
        exp_q.delete();
        build_trace(0);
        void'(exp_q.pop_back());
        keep = exp_q.size() + 3;
        build_trace(0);
        while (exp_q.size() > keep) void'(exp_q.pop_back());
        repeat (2) exp_q.push_back(mk(0, 0, 0, 20'd0, 0, 1));
        bus.loop = 1'b1;
        pulse_start();
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
            o = observe();
            n_checks++;
            if (o.busy !== exp_q[k].busy || o.done !== exp_q[k].done || o.pwm_en !== exp_q[k].pwm_en ||
                o.idx !== exp_q[k].idx || (exp_q[k].par_care && o.par !== exp_q[k].par)) begin
                n_errors++;
                $display("FAIL loop cyc %0d: got %s, expected %s", k, fmt(o), fmt(exp_q[k]));
            end
            if (k == keep - 1) bus.stop = 1'b1;
        end
    endtask
`endif

    task automatic test_async_reset();
        exp_t o;
        write_entry(0, 20'd50, 1, 1'b0);
        write_entry(1, 20'd77, 3, 1'b1);
        exp_q.delete();
        build_trace(1);
        pulse_start();
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            o = observe();
            n_checks++;
            if (o.busy !== exp_q[k].busy || o.pwm_en !== exp_q[k].pwm_en || o.idx !== exp_q[k].idx ||
                (exp_q[k].par_care && o.par !== exp_q[k].par)) begin
                n_errors++;
                $display("FAIL pre_reset cyc %0d: got %s, expected %s", k, fmt(o), fmt(exp_q[k]));
            end
        end
        #2 rst_n = 1'b0;
        #1;
        o = observe();
        n_checks++;
        if (o !== mk(0, 0, 0, 20'd0, 0, 1)) begin
            n_errors++;
            $display("FAIL async_reset: got %s, expected all zero", fmt(o));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) mdl_tab[i] = '0;
        test_play("post_reset_table");
    endtask

    initial begin
        test_reset();
        test_two_note();
        test_rest();
        test_stop();
        test_terminator();
        test_table_end();
        test_live_write();
        test_back_to_back();
        test_random();
`ifdef MELODY_LOOP_EN
        test_loop();
`endif
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Table-driven note sequencer that drives the buzzer tone generator's `pwm_parameter`/`en` inputs. Software writes a small note table (period, duration, last flag) over a simple write port, then pulses `start`. The block plays each entry for an exact number of duration ticks, inserts a fixed articulation gap between notes, and reports `busy`/`done`. It sits between the Cortex-M0 APB/GPIO register glue and the tone PWM in the audio output path.

## Interface
- `DEPTH`, 16: note table entries; power of two, 2..64.
- `TICK_DIV`, 50000: clk cycles per duration tick (1 ms at 50 MHz); ≥1.
- `GAP_CYC`, 2500: silent cycles after each note; 0 allowed (no gap).
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: table write strobe.
- `wr_addr` in log2(DEPTH): table entry index.
- `wr_data` in 32: [19:0] period, [27:20] duration in ticks, [28] last, [31:29] ignored.
- `start` in 1: single-cycle start pulse.
- `stop` in 1: single-cycle abort pulse.
- `loop` in 1: repeat mode; present only with `MELODY_LOOP_EN`.
- `busy` out 1: high in any non-IDLE state.
- `done` out 1: one-cycle pulse on normal completion.
- `cur_idx` out log2(DEPTH): entry currently loaded.
- `pwm_en` out 1: tone enable to the PWM.
- `pwm_parameter` out 20: tone period to the PWM.

## Operation
- Reset: state IDLE; all outputs 0; all table entries 0; tick/duration/gap counters 0.
- Table is writable in any state. An entry is latched only at LOAD, so writes to the playing entry take effect on its next LOAD.
- States:
  - IDLE: `start` sets idx=0 and goes to LOAD. `start` is ignored while busy.
  - LOAD (1 cycle): reads entry[idx] and latches period, duration, and last. If duration==0, the entry is a terminator: go to IDLE with `done` (also in loop mode). Otherwise go to PLAY with the tick and duration counters loaded.
  - PLAY: `pwm_parameter`=period; `pwm_en`=(period!=0), so period 0 is a rest. Lasts exactly duration×TICK_DIV cycles, then goes to GAP, or skips GAP when GAP_CYC==0.
  - GAP: `pwm_en`=0 and `pwm_parameter` holds. Lasts GAP_CYC cycles. Then:
    - If not last and idx≠DEPTH-1: idx+1, go to LOAD.
    - Otherwise: go to IDLE with `done`, or wrap (see Configuration).
- `stop` in any busy state forces IDLE on the next edge: `pwm_en`=0, `pwm_parameter`=0, no `done`. `stop` has priority over every other transition and over a same-cycle `start`.
- `cur_idx` = idx, updated on entry to LOAD. It holds its last value in IDLE.
- Duration counter is 8 bits, so the maximum note is 255 ticks. The tick counter width is clog2(TICK_DIV).

## Timing
- All outputs are registered and change on the state-transition edge.
- Cycle labels: start sampled at edge t. LOAD is cycle t+1 (`busy`=1, `pwm_en`=0). PLAY starts at t+2.
- `pwm_en` is high for exactly D×TICK_DIV consecutive cycles (D = duration, period ≠ 0).
- Between consecutive notes, `pwm_en` is low for GAP_CYC+1 cycles (gap plus LOAD).
- Completion: `done`=1 and `busy`=0 in the same first IDLE cycle; `pwm_en`=0 and `pwm_parameter`=0 there.
- Terminator path: `done` comes one cycle after its LOAD.
- A `start` in the same cycle as `done` is accepted.
- Reset asserted mid-note: all outputs go to 0 immediately (asynchronously).

## Configuration
- `MELODY_LOOP_EN` defined:
  - Port `loop` exists and is sampled at start.
  - If set, end-of-table (last flag or idx==DEPTH-1) goes to LOAD with idx=0 instead of IDLE. No `done` is pulsed; only `stop` or a terminator ends playback.
  - The gap before the wrap is still inserted.
- `MELODY_LOOP_EN` undefined: no `loop` port; playback is always one-shot.

## Test plan
Parameters for all scenarios: DEPTH=4, TICK_DIV=4, GAP_CYC=2.
- Two-note melody. Entry0={100,3}, entry1={200,2,last}; start. Required: `pwm_en` high 12 cycles at `pwm_parameter` 100, low 3, high 8 at 200, low 2. Then `done` pulse, `busy`=0, `pwm_parameter`=0.
- Rest note. Entry0={0,2,last}. Required: `busy` high, `pwm_en` low throughout, PLAY lasts 8 cycles, `done` after the 2-cycle gap.
- Stop mid-note. Stop at cycle 5 of PLAY. Required: next cycle `pwm_en`=0, `busy`=0, `pwm_parameter`=0, no `done`. A `start` issued mid-note is ignored.
- Terminator and table end:
  - Entry1 duration 0: `done` one cycle after entry1's LOAD, `cur_idx`=1.
  - No last flags, all durations 1: plays 4 entries, then `done`.
- Live write. Rewrite entry1 to period 300 during entry0's PLAY. Required: entry1 plays at 300.
- Loop (`MELODY_LOOP_EN`, loop=1). Required: after entry1's gap, LOAD idx 0 with no `done`. A `stop` then ends playback with no `done`.
